execute_pipe: RTL and testbench

// - Execute slice of the 5-stage RV32I pipeline: ID/EX pipeline register, EX operand forwarding/select, ALU, EX/MEM pipeline register.
// - Sits between decode (reg file + ctrl unit) and the LSU.
// - Stall/flush come from hazard_detect; forward selects from forwarding_unit; imm from external immgen.

---
 rtl/exec_pkg.sv | 92 +++++++++
 rtl/exec_alu.sv | 39 +++
 rtl/execute_pipe.sv | 132 +++++++++++++
 tb/tb_execute_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module  : exec_pkg
// Brief   : Shared types and constants for the RV32I execute slice
//           (control bundles, ALU opcodes, forwarding and writeback selects).
// Revision: 1.0 - initial release
// ============================================================================
package exec_pkg;

  localparam int DATA_W = 32;

  // ALU operation encoding; values 11-15 are reserved and produce zero
  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLT    = 4'd2,
    ALU_SLTU   = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_OR     = 4'd5,
    ALU_AND    = 4'd6,
    ALU_SLL    = 4'd7,
    ALU_SRL    = 4'd8,
    ALU_SRA    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  // Forwarding source selects; 2'b11 forces the operand to zero
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  // Writeback source selects
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  // Decoded control bundle from the ctrl unit (16 bits, MSB first)
  typedef struct packed {
    logic       is_rs2;
    logic       rd_wren;
    logic       is_load;
    logic       mem_wren;
    logic       op_a_sel;
    logic       op_b_sel;
    logic       br_unsigned;
    logic [1:0] wb_sel;
    logic [2:0] mem_op;
    logic [3:0] alu_op;
  } ctrl_t;

  // Control subset still needed after EX (8 bits, MSB first)
  typedef struct packed {
    logic       rd_wren;
    logic       is_load;
    logic       mem_wren;
    logic [1:0] wb_sel;
    logic [2:0] mem_op;
  } me_ctrl_t;

  // ID/EX pipeline register contents
  typedef struct packed {
    ctrl_t              ctrl;
    logic [DATA_W-1:0]  pc;
    logic [DATA_W-1:0]  instr;
    logic [DATA_W-1:0]  rs1;
    logic [DATA_W-1:0]  rs2;
    logic               btb_taken;
    logic [DATA_W-1:0]  btb_pc;
  } id_ex_t;

  // EX/MEM pipeline register contents
  typedef struct packed {
    me_ctrl_t           ctrl;
    logic [DATA_W-1:0]  pc;
    logic [DATA_W-1:0]  instr;
    logic [DATA_W-1:0]  rs2;
    logic [DATA_W-1:0]  alu;
  } ex_me_t;

  // Strip the EX-only control bits when handing an instruction to MEM
  function automatic me_ctrl_t to_me_ctrl(input ctrl_t c);
    me_ctrl_t m;
    m.rd_wren  = c.rd_wren;
    m.is_load  = c.is_load;
    m.mem_wren = c.mem_wren;
    m.wb_sel   = c.wb_sel;
    m.mem_op   = c.mem_op;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exec_alu.sv
`default_nettype none
// ============================================================================
// Module  : exec_alu
// Brief   : Pure combinational RV32I ALU, zero latency, no flags.
// Revision: 1.0 - initial release
// ============================================================================
module exec_alu
  import exec_pkg::*;
(
  input  logic [3:0]        alu_op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  // Operation select; reserved opcodes fall through to zero
  always_comb begin
    result_o = '0;
    case (alu_op_i)
      ALU_ADD:    result_o = a_i + b_i;
      ALU_SUB:    result_o = a_i - b_i;
      ALU_SLT:    result_o = {31'd0, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU:   result_o = {31'd0, (a_i < b_i)};
      ALU_XOR:    result_o = a_i ^ b_i;
      ALU_OR:     result_o = a_i | b_i;
      ALU_AND:    result_o = a_i & b_i;
      ALU_SLL:    result_o = a_i << shamt;
      ALU_SRL:    result_o = a_i >> shamt;
      ALU_SRA:    result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_PASS_B: result_o = b_i;
      default:    result_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/execute_pipe.sv
`default_nettype none
// ============================================================================
// Module  : execute_pipe
// Brief   : RV32I execute slice: ID/EX register, operand forwarding and
//           select, ALU, EX/MEM register. Only XLEN = 32 is supported.
// Revision: 1.0 - initial release
// ============================================================================
module execute_pipe
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_ex_i,
  input  logic            flush_ex_i,
  input  logic            en_me_i,
  input  logic            flush_me_i,
  input  ctrl_t           id_ctrl_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_instr_i,
  input  logic [XLEN-1:0] id_rs1_i,
  input  logic [XLEN-1:0] id_rs2_i,
  input  logic            id_btb_taken_i,
  input  logic [XLEN-1:0] id_btb_pc_i,
  input  logic [XLEN-1:0] ex_imm_i,
  input  logic [1:0]      fwd_a_i,
  input  logic [1:0]      fwd_b_i,
  input  logic [XLEN-1:0] wb_data_i,
  output ctrl_t           ex_ctrl_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_instr_o,
  output logic            ex_btb_taken_o,
  output logic [XLEN-1:0] ex_btb_pc_o,
  output logic [XLEN-1:0] ex_rs1_fwd_o,
  output logic [XLEN-1:0] ex_rs2_fwd_o,
  output logic [XLEN-1:0] ex_alu_o,
  output me_ctrl_t        me_ctrl_o,
  output logic [XLEN-1:0] me_pc_o,
  output logic [XLEN-1:0] me_instr_o,
  output logic [XLEN-1:0] me_rs2_o,
  output logic [XLEN-1:0] me_alu_o
);

  id_ex_t          idex_d, idex_q;
  ex_me_t          exme_d, exme_q;
  logic [XLEN-1:0] op_a, op_b;

  // ID/EX next state: flush beats enable, so a stalled slot can still be bubbled
  always_comb begin
    idex_d = idex_q;
    if (flush_ex_i) begin
      idex_d = '0;
    end else if (en_ex_i) begin
      idex_d = '{ctrl:      id_ctrl_i,
                 pc:        id_pc_i,
                 instr:     id_instr_i,
                 rs1:       id_rs1_i,
                 rs2:       id_rs2_i,
                 btb_taken: id_btb_taken_i,
                 btb_pc:    id_btb_pc_i};
    end
  end

  // ID/EX register; all-zero state is a non-writing bubble
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  // Operand forwarding; the 2'b11 select deliberately yields zero
  always_comb begin
    ex_rs1_fwd_o = '0;
    ex_rs2_fwd_o = '0;
    case (fwd_a_i)
      FWD_NONE: ex_rs1_fwd_o = idex_q.rs1;
      FWD_MEM:  ex_rs1_fwd_o = exme_q.alu;
      FWD_WB:   ex_rs1_fwd_o = wb_data_i;
      default:  ex_rs1_fwd_o = '0;
    endcase
    case (fwd_b_i)
      FWD_NONE: ex_rs2_fwd_o = idex_q.rs2;
      FWD_MEM:  ex_rs2_fwd_o = exme_q.alu;
      FWD_WB:   ex_rs2_fwd_o = wb_data_i;
      default:  ex_rs2_fwd_o = '0;
    endcase
  end

  assign op_a = idex_q.ctrl.op_a_sel ? idex_q.pc : ex_rs1_fwd_o;
  assign op_b = idex_q.ctrl.op_b_sel ? ex_imm_i  : ex_rs2_fwd_o;

  exec_alu u_alu (
    .alu_op_i (idex_q.ctrl.alu_op),
    .a_i      (op_a),
    .b_i      (op_b),
    .result_o (ex_alu_o)
  );

  // EX/MEM next state; store data is the forwarded rs2, not the raw reg value
  always_comb begin
    exme_d = exme_q;
    if (flush_me_i) begin
      exme_d = '0;
    end else if (en_me_i) begin
      exme_d = '{ctrl:  to_me_ctrl(idex_q.ctrl),
                 pc:    idex_q.pc,
                 instr: idex_q.instr,
                 rs2:   ex_rs2_fwd_o,
                 alu:   ex_alu_o};
    end
  end

  // EX/MEM register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) exme_q <= '0;
    else       exme_q <= exme_d;
  end

  assign ex_ctrl_o      = idex_q.ctrl;
  assign ex_pc_o        = idex_q.pc;
  assign ex_instr_o     = idex_q.instr;
  assign ex_btb_taken_o = idex_q.btb_taken;
  assign ex_btb_pc_o    = idex_q.btb_pc;

  assign me_ctrl_o  = exme_q.ctrl;
  assign me_pc_o    = exme_q.pc;
  assign me_instr_o = exme_q.instr;
  assign me_rs2_o   = exme_q.rs2;
  assign me_alu_o   = exme_q.alu;

endmodule
`default_nettype wire

// File: tb/tb_execute_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_execute_pipe
// Brief   : Directed self-checking bench for execute_pipe.
// Revision: 1.0 - initial release
// ============================================================================
module tb_execute_pipe;
  import exec_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_ex_i, flush_ex_i, en_me_i, flush_me_i;
  ctrl_t       id_ctrl_i;
  logic [31:0] id_pc_i, id_instr_i, id_rs1_i, id_rs2_i;
  logic        id_btb_taken_i;
  logic [31:0] id_btb_pc_i, ex_imm_i;
  logic [1:0]  fwd_a_i, fwd_b_i;
  logic [31:0] wb_data_i;
  ctrl_t       ex_ctrl_o;
  logic [31:0] ex_pc_o, ex_instr_o;
  logic        ex_btb_taken_o;
  logic [31:0] ex_btb_pc_o, ex_rs1_fwd_o, ex_rs2_fwd_o, ex_alu_o;
  me_ctrl_t    me_ctrl_o;
  logic [31:0] me_pc_o, me_instr_o, me_rs2_o, me_alu_o;

  int n_cmp = 0;
  int n_err = 0;

  execute_pipe #(.XLEN(32)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .en_ex_i        (en_ex_i),
    .flush_ex_i     (flush_ex_i),
    .en_me_i        (en_me_i),
    .flush_me_i     (flush_me_i),
    .id_ctrl_i      (id_ctrl_i),
    .id_pc_i        (id_pc_i),
    .id_instr_i     (id_instr_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .id_btb_taken_i (id_btb_taken_i),
    .id_btb_pc_i    (id_btb_pc_i),
    .ex_imm_i       (ex_imm_i),
    .fwd_a_i        (fwd_a_i),
    .fwd_b_i        (fwd_b_i),
    .wb_data_i      (wb_data_i),
    .ex_ctrl_o      (ex_ctrl_o),
    .ex_pc_o        (ex_pc_o),
    .ex_instr_o     (ex_instr_o),
    .ex_btb_taken_o (ex_btb_taken_o),
    .ex_btb_pc_o    (ex_btb_pc_o),
    .ex_rs1_fwd_o   (ex_rs1_fwd_o),
    .ex_rs2_fwd_o   (ex_rs2_fwd_o),
    .ex_alu_o       (ex_alu_o),
    .me_ctrl_o      (me_ctrl_o),
    .me_pc_o        (me_pc_o),
    .me_instr_o     (me_instr_o),
    .me_rs2_o       (me_rs2_o),
    .me_alu_o       (me_alu_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic ctrl_t mk_ctrl(input logic [3:0] op, input logic a_sel, input logic b_sel);
    ctrl_t c;
    c          = '0;
    c.alu_op   = op;
    c.op_a_sel = a_sel;
    c.op_b_sel = b_sel;
    c.rd_wren  = 1'b1;
    return c;
  endfunction

  task automatic drive_id(input ctrl_t c, input logic [31:0] pc, input logic [31:0] instr,
                          input logic [31:0] rs1, input logic [31:0] rs2);
    id_ctrl_i  = c;
    id_pc_i    = pc;
    id_instr_i = instr;
    id_rs1_i   = rs1;
    id_rs2_i   = rs2;
  endtask

  // Register-register ALU case: load into EX, then check the combinational result
  task automatic alu_case(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    drive_id(mk_ctrl(op, 1'b0, 1'b0), 32'h0000_0040, 32'h0000_0033, a, b);
    tick();
    chk(tag, ex_alu_o, exp);
  endtask

  initial begin
    rst_i = 1'b1;
    en_ex_i = 1'b0; flush_ex_i = 1'b0; en_me_i = 1'b0; flush_me_i = 1'b0;
    drive_id('0, '0, '0, '0, '0);
    id_btb_taken_i = 1'b0; id_btb_pc_i = '0; ex_imm_i = '0;
    fwd_a_i = FWD_NONE; fwd_b_i = FWD_NONE; wb_data_i = '0;

    // Reset state
    tick(); tick();
    chk("rst_ex_pc",    ex_pc_o, 32'h0);
    chk("rst_ex_instr", ex_instr_o, 32'h0);
    chk("rst_ex_ctrl",  32'(ex_ctrl_o), 32'h0);
    chk("rst_ex_alu",   ex_alu_o, 32'h0);
    chk("rst_me_ctrl",  32'(me_ctrl_o), 32'h0);
    chk("rst_me_alu",   me_alu_o, 32'h0);
    rst_i = 1'b0;
    en_ex_i = 1'b1; en_me_i = 1'b1;

    // ADD 5+7: 12 in EX after one edge, in MEM after the next
    drive_id(mk_ctrl(ALU_ADD, 1'b0, 1'b0), 32'h0000_0100, 32'h0073_02B3, 32'd5, 32'd7);
    tick();
    chk("add_ex_alu", ex_alu_o, 32'd12);
    chk("add_ex_pc",  ex_pc_o, 32'h0000_0100);
    tick();
    chk("add_me_alu",   me_alu_o, 32'd12);
    chk("add_me_pc",    me_pc_o, 32'h0000_0100);
    chk("add_me_instr", me_instr_o, 32'h0073_02B3);
    chk("add_me_ctrl",  32'(me_ctrl_o), 32'h0000_0080); // rd_wren is the MSB of me_ctrl_t

    // ALU function table
    alu_case("sub_wrap", ALU_SUB,  32'h0000_0000, 32'd1,  32'hFFFF_FFFF);
    alu_case("sra",      ALU_SRA,  32'h8000_0000, 32'd4,  32'hF800_0000);
    alu_case("srl",      ALU_SRL,  32'h8000_0000, 32'd4,  32'h0800_0000);
    alu_case("sll",      ALU_SLL,  32'h0000_0001, 32'd31, 32'h8000_0000);
    alu_case("sra_shamt5", ALU_SRA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
    alu_case("slt",      ALU_SLT,  32'hFFFF_FFFF, 32'd1,  32'd1);
    alu_case("sltu",     ALU_SLTU, 32'hFFFF_FFFF, 32'd1,  32'd0);
    alu_case("xor",      ALU_XOR,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
    alu_case("or",       ALU_OR,   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
    alu_case("and",      ALU_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    alu_case("op12_zero", 4'd12,   32'd5, 32'd7, 32'd0);
    alu_case("op15_zero", 4'd15,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);

    // LUI via immediate and PC-relative add
    ex_imm_i = 32'h1234_5000;
    drive_id(mk_ctrl(ALU_PASS_B, 1'b0, 1'b1), 32'h0000_0044, 32'h1234_50B7, 32'h0000_0077, 32'h0000_0099);
    tick();
    chk("pass_b_imm", ex_alu_o, 32'h1234_5000);
    ex_imm_i = 32'd8;
    drive_id(mk_ctrl(ALU_ADD, 1'b1, 1'b1), 32'h0000_0200, 32'h0000_0097, 32'h0000_0077, 32'h0000_0099);
    tick();
    chk("pc_plus_imm", ex_alu_o, 32'h0000_0208);
    ex_imm_i = '0;

    // Forwarding: producer 0xA0+0x0A=0xAA, then a store consuming it
    drive_id(mk_ctrl(ALU_ADD, 1'b0, 1'b0), 32'h0000_0210, 32'h0000_0033, 32'h0000_00A0, 32'h0000_000A);
    tick();
    id_ctrl_i          = mk_ctrl(ALU_ADD, 1'b0, 1'b0);
    id_ctrl_i.rd_wren  = 1'b0;
    id_ctrl_i.mem_wren = 1'b1;
    id_pc_i = 32'h0000_0214; id_instr_i = 32'h0000_0023; id_rs1_i = 32'd1; id_rs2_i = 32'd2;
    tick();
    fwd_a_i = FWD_MEM;
    #1;
    chk("fwd_a_mem",     ex_rs1_fwd_o, 32'h0000_00AA);
    chk("fwd_a_alu",     ex_alu_o, 32'h0000_00AC);
    fwd_b_i = FWD_WB; wb_data_i = 32'h0000_0055;
    #1;
    chk("fwd_b_wb",      ex_rs2_fwd_o, 32'h0000_0055);
    chk("fwd_ab_alu",    ex_alu_o, 32'h0000_00FF);
    tick();
    chk("fwd_me_rs2",    me_rs2_o, 32'h0000_0055);
    chk("fwd_me_alu",    me_alu_o, 32'h0000_00FF);
    chk("fwd_me_ctrl",   32'(me_ctrl_o), 32'h0000_0020); // mem_wren only
    fwd_a_i = 2'b11; fwd_b_i = 2'b11;
    #1;
    chk("fwd_a_11_zero", ex_rs1_fwd_o, 32'h0);
    chk("fwd_b_11_zero", ex_rs2_fwd_o, 32'h0);
    fwd_a_i = FWD_NONE; fwd_b_i = FWD_NONE; wb_data_i = '0;

    // Stall: load X, then hold EX for three edges while ID changes
    drive_id(mk_ctrl(ALU_ADD, 1'b0, 1'b0), 32'h0000_0300, 32'h1230_0093, 32'd3, 32'd4);
    id_btb_taken_i = 1'b1; id_btb_pc_i = 32'h0000_0500;
    tick();
    chk("x_ex_pc",     ex_pc_o, 32'h0000_0300);
    chk("x_btb_pc",    ex_btb_pc_o, 32'h0000_0500);
    chk("x_btb_taken", 32'(ex_btb_taken_o), 32'd1);
    en_ex_i = 1'b0; en_me_i = 1'b0;
    drive_id(mk_ctrl(ALU_SUB, 1'b0, 1'b0), 32'h0000_0400, 32'hDEAD_BEEF, 32'd9, 32'd9);
    id_btb_taken_i = 1'b0; id_btb_pc_i = 32'h0000_0600;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ex_pc",    ex_pc_o, 32'h0000_0300);
      chk("stall_ex_instr", ex_instr_o, 32'h1230_0093);
      chk("stall_ex_alu",   ex_alu_o, 32'd7);
    end

    // Flush EX while stalled, with MEM still capturing the outgoing X
    flush_ex_i = 1'b1; en_me_i = 1'b1;
    tick();
    flush_ex_i = 1'b0;
    chk("flush_ex_pc",    ex_pc_o, 32'h0);
    chk("flush_ex_instr", ex_instr_o, 32'h0);
    chk("flush_ex_ctrl",  32'(ex_ctrl_o), 32'h0);
    chk("flush_ex_btb",   ex_btb_pc_o, 32'h0);
    chk("flush_ex_btbt",  32'(ex_btb_taken_o), 32'h0);
    chk("flush_me_pc_x",  me_pc_o, 32'h0000_0300);
    chk("flush_me_alu_x", me_alu_o, 32'd7);
    chk("flush_me_ins_x", me_instr_o, 32'h1230_0093);

    // Flush MEM with its enable low
    flush_me_i = 1'b1; en_me_i = 1'b0;
    tick();
    flush_me_i = 1'b0;
    chk("flush_me_alu",  me_alu_o, 32'h0);
    chk("flush_me_pc",   me_pc_o, 32'h0);
    chk("flush_me_ctrl", 32'(me_ctrl_o), 32'h0);

    // Asynchronous reset between edges
    en_ex_i = 1'b1; en_me_i = 1'b1;
    drive_id(mk_ctrl(ALU_ADD, 1'b0, 1'b0), 32'h0000_0600, 32'h0000_0033, 32'd5, 32'd7);
    tick(); tick();
    chk("pre_arst_me_alu", me_alu_o, 32'd12);
    #3;
    rst_i = 1'b1;
    #1;
    chk("arst_ex_pc",    ex_pc_o, 32'h0);
    chk("arst_ex_instr", ex_instr_o, 32'h0);
    chk("arst_me_alu",   me_alu_o, 32'h0);
    chk("arst_me_pc",    me_pc_o, 32'h0);
    chk("arst_me_ctrl",  32'(me_ctrl_o), 32'h0);
    #1;
    rst_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
